// File: rtl/bus_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : bus_pkg
//  Description : Shared state encoding and default parameter constants for
//                the serial slave memory.
//  Revision    : 1.0 - initial release
// ============================================================================
package bus_pkg;

  localparam int c_def_addr_width      = 12;
  localparam int c_def_data_width      = 8;
  localparam int c_def_burst_width     = 12;
  localparam int c_def_split_threshold = 16;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ADDR  = 3'd1,
    BURST = 3'd2,
    WRITE = 3'd3,
    DELAY = 3'd4,
    READ  = 3'd5,
    SEND  = 3'd6
  } state_t;

  // States in which the slave is willing to accept serial bits from the master
  function automatic logic is_rx_state(input state_t s);
    return (s == ADDR) || (s == BURST) || (s == WRITE);
  endfunction

endpackage
`default_nettype wire

// File: rtl/slave_mem_array.sv
`default_nettype none
// ============================================================================
//  Module      : slave_mem_array
//  Description : Single-port synchronous RAM, read-first, no reset on the
//                storage so it maps onto block RAM.
//  Revision    : 1.0 - initial release
// ============================================================================
module slave_mem_array #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] r_mem [2**ADDR_WIDTH];

  // Synchronous write plus registered read of the same address
  always_ff @(posedge clk) begin
    if (we) begin
      r_mem[addr] <= wdata;
    end
    rdata <= r_mem[addr];
  end

endmodule
`default_nettype wire

// File: rtl/slave_mem.sv
`default_nettype none
// ============================================================================
//  Module      : slave_mem
//  Description : Bit-serial bus slave in front of a RAM. Receives address,
//                burst length and write data serially (LSB first), returns
//                read data serially, and can request a bus split during a
//                long read wait.
//  Revision    : 1.0 - initial release
// ============================================================================
module slave_mem
  import bus_pkg::*;
#(
  parameter int ADDR_WIDTH      = c_def_addr_width,
  parameter int DATA_WIDTH      = c_def_data_width,
  parameter int BURST_WIDTH     = c_def_burst_width,
  parameter int SPLIT_THRESHOLD = c_def_split_threshold
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [5:0]            slave_delay,
  input  logic                  read_en,
  input  logic                  write_en,
  input  logic                  master_valid,
  input  logic                  master_ready,
  output logic                  slave_valid,
  output logic                  slave_ready,
  input  logic                  rx_address,
  input  logic                  rx_burst,
  input  logic                  rx_data,
  output logic                  tx_data,
  output logic                  split_en,
  output logic [DATA_WIDTH-1:0] data_out
);

  localparam int                 c_cnt_w      = 16;
  localparam logic [c_cnt_w-1:0] c_addr_last  = c_cnt_w'(ADDR_WIDTH - 1);
  localparam logic [c_cnt_w-1:0] c_burst_last = c_cnt_w'(BURST_WIDTH - 1);
  localparam logic [c_cnt_w-1:0] c_data_last  = c_cnt_w'(DATA_WIDTH - 1);
  localparam logic [31:0]        c_split_thr  = 32'(SPLIT_THRESHOLD);
  localparam logic [BURST_WIDTH-1:0] c_one_beat = BURST_WIDTH'(1);

  state_t                   r_state;
  state_t                   w_next;
  logic [ADDR_WIDTH-1:0]    r_addr;
  logic [BURST_WIDTH-2:0]   r_burst_sh;   // first BURST_WIDTH-1 burst bits
  logic [BURST_WIDTH-1:0]   r_beats;      // beats still to transfer
  logic [DATA_WIDTH-2:0]    r_wshift;     // first DATA_WIDTH-1 write bits
  logic [DATA_WIDTH-1:0]    r_wdata;      // completed word awaiting write
  logic [DATA_WIDTH-1:0]    r_tx;
  logic [c_cnt_w-1:0]       r_cnt;
  logic [5:0]               r_delay;
  logic                     r_is_read;
  logic                     r_wr_pend;
  logic                     r_rd_phase;   // 0: read issued, 1: data available
  logic [DATA_WIDTH-1:0]    w_rdata;
  logic [BURST_WIDTH-1:0]   w_burst_val;
  logic [c_cnt_w-1:0]       w_delay_last;
  logic                     w_rx_fire;
  logic                     w_tx_fire;
  logic                     w_last_beat;

  assign slave_ready  = is_rx_state(r_state);
  assign slave_valid  = (r_state == SEND);
  assign split_en     = (r_state == DELAY) && (32'(r_delay) >= c_split_thr);
  assign tx_data      = (r_state == SEND) ? r_tx[0] : 1'b0;
  assign w_rx_fire    = master_valid & slave_ready;
  assign w_tx_fire    = slave_valid & master_ready;
  assign w_burst_val  = {rx_burst, r_burst_sh};
  assign w_delay_last = c_cnt_w'(r_delay) - 1'b1;
  assign w_last_beat  = (r_beats == c_one_beat);

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state decode
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (master_valid && (read_en ^ write_en)) begin
          w_next = ADDR;
        end
      end
      ADDR: begin
        if (w_rx_fire && (r_cnt == c_addr_last)) begin
          w_next = BURST;
        end
      end
      BURST: begin
        if (w_rx_fire && (r_cnt == c_burst_last)) begin
          if (!r_is_read) begin
            w_next = WRITE;
          end else if (slave_delay == 6'd0) begin
            w_next = READ;
          end else begin
            w_next = DELAY;
          end
        end
      end
      WRITE: begin
        if (w_rx_fire && (r_cnt == c_data_last) && w_last_beat) begin
          w_next = IDLE;
        end
      end
      DELAY: begin
        if (r_cnt == w_delay_last) begin
          w_next = READ;
        end
      end
      READ: begin
        if (r_rd_phase) begin
          w_next = SEND;
        end
      end
      SEND: begin
        if (w_tx_fire && (r_cnt == c_data_last)) begin
          w_next = w_last_beat ? IDLE : READ;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  // Datapath: shifters, counters, address and pending write
  always_ff @(posedge clk) begin
    if (reset) begin
      r_addr     <= '0;
      r_burst_sh <= '0;
      r_beats    <= '0;
      r_wshift   <= '0;
      r_wdata    <= '0;
      r_tx       <= '0;
      r_cnt      <= '0;
      r_delay    <= '0;
      r_is_read  <= 1'b0;
      r_wr_pend  <= 1'b0;
      r_rd_phase <= 1'b0;
      data_out   <= '0;
    end else begin
      // A completed word is committed the cycle after its last bit
      if (r_wr_pend) begin
        r_wr_pend <= 1'b0;
        r_addr    <= r_addr + 1'b1;
        data_out  <= r_wdata;
      end

      case (r_state)
        IDLE: begin
          r_cnt      <= '0;
          r_rd_phase <= 1'b0;
          if (w_next == ADDR) begin
            r_is_read <= read_en;
          end
        end
        ADDR: begin
          if (w_rx_fire) begin
            r_addr <= {rx_address, r_addr[ADDR_WIDTH-1:1]};
            r_cnt  <= (r_cnt == c_addr_last) ? '0 : r_cnt + 1'b1;
          end
        end
        BURST: begin
          if (w_rx_fire) begin
            r_burst_sh <= w_burst_val[BURST_WIDTH-1:1];
            if (r_cnt == c_burst_last) begin
              r_cnt   <= '0;
              r_delay <= slave_delay;
              r_beats <= (w_burst_val == '0) ? c_one_beat : w_burst_val;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end
        WRITE: begin
          if (w_rx_fire) begin
            r_wshift <= {rx_data, r_wshift[DATA_WIDTH-2:1]};
            if (r_cnt == c_data_last) begin
              r_cnt     <= '0;
              r_wdata   <= {rx_data, r_wshift};
              r_wr_pend <= 1'b1;
              r_beats   <= r_beats - 1'b1;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end
        DELAY: begin
          r_cnt <= (w_next == DELAY) ? r_cnt + 1'b1 : '0;
        end
        READ: begin
          if (!r_rd_phase) begin
            r_rd_phase <= 1'b1;
          end else begin
            r_rd_phase <= 1'b0;
            r_tx       <= w_rdata;
            data_out   <= w_rdata;
            r_cnt      <= '0;
          end
        end
        SEND: begin
          if (w_tx_fire) begin
            r_tx <= r_tx >> 1;
            if (r_cnt == c_data_last) begin
              r_cnt   <= '0;
              r_addr  <= r_addr + 1'b1;
              r_beats <= r_beats - 1'b1;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end
        default: r_cnt <= '0;
      endcase
    end
  end

  slave_mem_array #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_array (
    .clk   (clk),
    .we    (r_wr_pend & ~reset),
    .addr  (r_addr),
    .wdata (r_wdata),
    .rdata (w_rdata)
  );

endmodule
`default_nettype wire

// File: tb/tb_slave_mem.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_slave_mem
//  Description : Randomised scoreboard bench for slave_mem with an
//                associative-array memory model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_slave_mem;

  localparam int AW    = 12;
  localparam int DW    = 8;
  localparam int BW    = 12;
  localparam int DEPTH = 1 << AW;
  localparam int SPLIT = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [5:0]    slave_delay = 6'd0;
  logic          read_en = 1'b0;
  logic          write_en = 1'b0;
  logic          master_valid = 1'b0;
  logic          master_ready = 1'b1;
  logic          rx_address = 1'b0;
  logic          rx_burst = 1'b0;
  logic          rx_data = 1'b0;
  logic          slave_valid;
  logic          slave_ready;
  logic          tx_data;
  logic          split_en;
  logic [DW-1:0] data_out;

  int n_tests = 0;
  int n_fail  = 0;

  logic [DW-1:0] mem_model [int];
  logic [DW-1:0] exp_q [$];
  logic [DW-1:0] wr_words [$];
  int            hist_a [$];
  int            hist_n [$];

  int            mon_bits = 0;
  int            words_done = 0;
  int            split_cycles = 0;
  logic [DW-1:0] mon_word = '0;
  logic [DW-1:0] mon_exp;
  logic          prev_stall = 1'b0;
  logic          prev_tx = 1'b0;

  slave_mem #(
    .ADDR_WIDTH      (AW),
    .DATA_WIDTH      (DW),
    .BURST_WIDTH     (BW),
    .SPLIT_THRESHOLD (SPLIT)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .slave_delay  (slave_delay),
    .read_en      (read_en),
    .write_en     (write_en),
    .master_valid (master_valid),
    .master_ready (master_ready),
    .slave_valid  (slave_valid),
    .slave_ready  (slave_ready),
    .rx_address   (rx_address),
    .rx_burst     (rx_burst),
    .rx_data      (rx_data),
    .tx_data      (tx_data),
    .split_en     (split_en),
    .data_out     (data_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Monitor: assembles tx words, pops expected words, watches stalls and split
  always @(negedge clk) begin
    if (split_en) split_cycles++;
    if (prev_stall && slave_valid) check("tx_hold", 32'(tx_data), 32'(prev_tx));
    prev_stall = slave_valid && !master_ready;
    prev_tx    = tx_data;
    if (reset) begin
      mon_bits = 0;
    end else if (slave_valid && master_ready) begin
      mon_word[mon_bits] = tx_data;
      mon_bits++;
      if (mon_bits == DW) begin
        mon_bits = 0;
        words_done++;
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_word: got 0x%0h, expected none", mon_word);
        end else begin
          mon_exp = exp_q.pop_front();
          check("rd_word", 32'(mon_word), 32'(mon_exp));
          check("rd_data_out", 32'(data_out), 32'(mon_exp));
        end
      end
    end
  end

  // One rx bit, held until the slave accepts it
  task automatic rx_bit(input logic a, input logic b, input logic d);
    logic rdy;
    int   n;
    master_valid = 1'b0;
    repeat ($urandom_range(0, 1)) tick();
    rx_address   = a;
    rx_burst     = b;
    rx_data      = d;
    master_valid = 1'b1;
    n = 0;
    forever begin
      @(negedge clk);
      rdy = slave_ready;
      tick();
      if (rdy) break;
      n++;
      if (n > 50) begin
        n_tests++;
        n_fail++;
        $display("FAIL rx_timeout: got slave_ready=0, expected 1 within 50 cycles");
        break;
      end
    end
    master_valid = 1'b0;
  endtask

  task automatic start_xact(input logic rd);
    read_en      = rd;
    write_en     = !rd;
    master_valid = 1'b1;
    tick();
    // direction is latched; later values must not matter
    read_en      = 1'($urandom_range(0, 1));
    write_en     = 1'($urandom_range(0, 1));
    master_valid = 1'b0;
  endtask

  task automatic send_hdr(input int addr, input int burst);
    for (int i = 0; i < AW; i++) rx_bit(1'((addr >> i) & 1), 1'b0, 1'b0);
    for (int i = 0; i < BW; i++) rx_bit(1'b0, 1'((burst >> i) & 1), 1'b0);
  endtask

  // Write transaction using the words in wr_words
  task automatic do_write(input int addr, input int burst);
    int beats;
    beats = (burst == 0) ? 1 : burst;
    start_xact(1'b0);
    send_hdr(addr, burst);
    for (int b = 0; b < beats; b++) begin
      for (int k = 0; k < DW; k++) rx_bit(1'b0, 1'b0, wr_words[b][k]);
      mem_model[(addr + b) % DEPTH] = wr_words[b];
    end
    read_en  = 1'b0;
    write_en = 1'b0;
    tick();
    check("wr_data_out", 32'(data_out), 32'(wr_words[beats-1]));
  endtask

  // Read transaction; mode 0 always ready, 1 random ready, 2 one 5-cycle stall
  task automatic do_read(input int addr, input int burst, input int dly, input int mode);
    int beats;
    int target;
    int budget;
    bit stalled;
    beats = (burst == 0) ? 1 : burst;
    for (int i = 0; i < beats; i++) exp_q.push_back(mem_model[(addr + i) % DEPTH]);
    target       = words_done + beats;
    split_cycles = 0;
    slave_delay  = 6'(dly);
    start_xact(1'b1);
    send_hdr(addr, burst);
    slave_delay  = 6'($urandom_range(0, 63));
    budget  = 0;
    stalled = 1'b0;
    while (words_done < target && budget < 3000) begin
      if (mode == 1) begin
        master_ready = 1'($urandom_range(0, 1));
      end else if (mode == 2 && !stalled && slave_valid && mon_bits == 3) begin
        master_ready = 1'b0;
        repeat (5) tick();
        stalled      = 1'b1;
        master_ready = 1'b1;
      end else begin
        master_ready = 1'b1;
      end
      tick();
      budget++;
    end
    if (budget >= 3000) begin
      n_tests++;
      n_fail++;
      $display("FAIL rd_timeout: got %0d words, expected %0d", words_done, target);
    end
    master_ready = 1'b1;
    read_en      = 1'b0;
    write_en     = 1'b0;
    tick();
    check("split_cycles", 32'(split_cycles), 32'((dly >= SPLIT) ? dly : 0));
  endtask

  initial begin : main
    logic seen;
    // Reset state
    repeat (3) tick();
    check("rst_slave_valid", 32'(slave_valid), 32'd0);
    check("rst_slave_ready", 32'(slave_ready), 32'd0);
    check("rst_split_en", 32'(split_en), 32'd0);
    check("rst_tx_data", 32'(tx_data), 32'd0);
    check("rst_data_out", 32'(data_out), 32'd0);
    reset = 1'b0;
    tick();

    // Single write then single read
    wr_words = '{8'hA5};
    do_write(12'h005, 1);
    do_read(12'h005, 1, 0, 0);

    // Burst with address wrap
    wr_words = '{8'h11, 8'h22, 8'h33};
    do_write(12'hFFE, 3);
    do_read(12'hFFE, 3, 0, 0);
    do_read(12'hFFF, 1, 2, 0);
    do_read(12'h000, 1, 1, 0);

    // Split signalling above and below threshold
    do_read(12'h005, 1, 20, 0);
    do_read(12'h005, 1, 15, 0);

    // Backpressure mid-word
    do_read(12'hFFE, 2, 0, 2);

    // Burst field of zero means one beat
    wr_words = '{8'h5A};
    do_write(12'h100, 0);
    do_read(12'h100, 0, 3, 0);

    // Reset after 4 of 8 write bits
    start_xact(1'b0);
    send_hdr(12'h005, 1);
    for (int k = 0; k < 4; k++) rx_bit(1'b0, 1'b0, 1'(k & 1));
    reset = 1'b1;
    tick();
    tick();
    check("abort_slave_ready", 32'(slave_ready), 32'd0);
    check("abort_data_out", 32'(data_out), 32'd0);
    reset    = 1'b0;
    read_en  = 1'b0;
    write_en = 1'b0;
    tick();
    check("abort_idle_ready", 32'(slave_ready), 32'd0);
    do_read(12'h005, 1, 0, 0);

    // Both enables asserted: no transaction may start
    read_en      = 1'b1;
    write_en     = 1'b1;
    master_valid = 1'b1;
    seen = 1'b0;
    repeat (10) begin
      @(negedge clk);
      seen = seen | slave_ready;
      tick();
    end
    read_en      = 1'b0;
    write_en     = 1'b0;
    master_valid = 1'b0;
    check("both_en_ready", 32'(seen), 32'd0);
    tick();

    // Randomised write/read pairs against the model
    for (int t = 0; t < 10; t++) begin
      int a, bu, n, h, off, len;
      a  = $urandom_range(0, DEPTH - 1);
      bu = $urandom_range(0, 4);
      n  = (bu == 0) ? 1 : bu;
      wr_words.delete();
      for (int b = 0; b < n; b++) wr_words.push_back(8'($urandom));
      do_write(a, bu);
      hist_a.push_back(a);
      hist_n.push_back(n);
      h   = $urandom_range(0, hist_a.size() - 1);
      off = $urandom_range(0, hist_n[h] - 1);
      len = $urandom_range(1, hist_n[h] - off);
      do_read((hist_a[h] + off) % DEPTH, len, $urandom_range(0, 24), $urandom_range(0, 1));
    end

    repeat (5) tick();
    check("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
